// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: generates the PDM microphone clock, samples the 1-bit PDM
// stream, decimates it with a 4th-order CIC filter and hands signed PCM samples
// to the packet builder over a valid/ready port with a sticky overrun flag.
// Optional feature: define PDM_DCBLOCK_EN to insert a DC-blocking high-pass
// stage between saturation and the output register (adds one clk of latency).
module pdm_cic_decimator #(
   parameter int CLK_DIV    = 10,
   parameter int DECIM_LOG2 = 6,
   parameter int OUT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    pdm_clk,
   input  logic                    pdm_data,
   output logic signed [OUT_W-1:0] sample,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    overrun
);
   localparam int W     = 4*DECIM_LOG2 + 2;
   localparam int SW    = W + OUT_W;
   localparam int SHIFT = 4*DECIM_LOG2 - OUT_W + 1;
   localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
   localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
   localparam logic [7:0]             DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [DECIM_LOG2-1:0]  DEC_ONE  = DECIM_LOG2'(1);
   localparam logic signed [W-1:0]    POS_ONE  = W'(1);
   localparam logic signed [W-1:0]    NEG_ONE  = '1;
   localparam logic signed [SW-1:0]   OUT_MAX  = SW'((64'd1 << (OUT_W-1)) - 64'd1);
   localparam logic signed [SW-1:0]   OUT_MIN  = ~OUT_MAX;

   // Comb result widened, then brought to output scale (right shift for large R).
   function automatic logic signed [SW-1:0] scale_out(input logic signed [W-1:0] v);
      logic signed [SW-1:0] e;
      e = {{OUT_W{v[W-1]}}, v};
      return (e >>> RSH) <<< LSH;
   endfunction

   // Clamp a wide signed value into the OUT_W output range.
   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SW-1:0] v);
      if (v > OUT_MAX) return OUT_MAX[OUT_W-1:0];
      else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
      return v[OUT_W-1:0];
   endfunction

   logic [7:0]            div_cnt;
   logic                  pdm_clk_d;
   logic                  sync_p0, sync_p1;
   logic                  tick;
   logic [DECIM_LOG2-1:0] dec_cnt;
   logic                  strobe;
   logic signed [W-1:0]   integ1_p0, integ2_p0, integ3_p0, integ4_p0;
   logic signed [W-1:0]   integ1_n, integ2_n, integ3_n, integ4_n;
   logic signed [W-1:0]   comb_dly1_p0, comb_dly2_p0, comb_dly3_p0, comb_dly4_p0;
   logic signed [W-1:0]   comb1, comb2, comb3, comb4;
   logic [2:0]            settle_cnt;
   logic                  settled;
   logic                  vld_p0;
   logic signed [OUT_W-1:0] pcm_p0;
   logic                  out_vld;
   logic signed [OUT_W-1:0] out_val;

   // pdm_clk divider; pdm_clk_d keeps the previous level so the fall can be seen
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         pdm_clk   <= 1'b0;
         pdm_clk_d <= 1'b0;
      end else begin
         pdm_clk_d <= pdm_clk;
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            pdm_clk <= ~pdm_clk;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end
   end

   assign tick = pdm_clk_d & ~pdm_clk;

   // two-flop synchronizer for the asynchronous microphone bit
   always_ff @(posedge clk) begin
      sync_p0 <= pdm_data;
      sync_p1 <= sync_p0;
   end

   // integrator cascade: each stage adds the freshly updated previous stage
   assign integ1_n = integ1_p0 + (sync_p1 ? POS_ONE : NEG_ONE);
   assign integ2_n = integ2_p0 + integ1_n;
   assign integ3_n = integ3_p0 + integ2_n;
   assign integ4_n = integ4_p0 + integ3_n;
   assign strobe   = tick && (dec_cnt == '1);

   // integrators and decimation counter advance once per PDM tick; wrap is harmless
   always_ff @(posedge clk) begin
      if (rst) begin
         integ1_p0 <= '0;
         integ2_p0 <= '0;
         integ3_p0 <= '0;
         integ4_p0 <= '0;
         dec_cnt   <= '0;
      end else if (tick) begin
         integ1_p0 <= integ1_n;
         integ2_p0 <= integ2_n;
         integ3_p0 <= integ3_n;
         integ4_p0 <= integ4_n;
         dec_cnt   <= dec_cnt + DEC_ONE;
      end
   end

   // comb cascade evaluated in the strobe cycle on the just-updated integrator 4
   assign comb1   = integ4_n - comb_dly1_p0;
   assign comb2   = comb1 - comb_dly2_p0;
   assign comb3   = comb2 - comb_dly3_p0;
   assign comb4   = comb3 - comb_dly4_p0;
   assign settled = (settle_cnt == 3'd4);
   assign vld_p0  = strobe && settled;
   assign pcm_p0  = sat_out(scale_out(comb4));

   // comb delay line and settle count step on each decimation strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         comb_dly1_p0 <= '0;
         comb_dly2_p0 <= '0;
         comb_dly3_p0 <= '0;
         comb_dly4_p0 <= '0;
         settle_cnt   <= '0;
      end else if (strobe) begin
         comb_dly1_p0 <= integ4_n;
         comb_dly2_p0 <= comb1;
         comb_dly3_p0 <= comb2;
         comb_dly4_p0 <= comb3;
         if (!settled) settle_cnt <= settle_cnt + 3'd1;
      end
   end

`ifdef PDM_DCBLOCK_EN
   localparam int DC_W = 24;
   localparam logic signed [DC_W+1:0] DC_MAX = 26'sd8388607;
   localparam logic signed [DC_W+1:0] DC_MIN = ~DC_MAX;

   logic signed [OUT_W-1:0] dc_x_p1;
   logic signed [DC_W-1:0]  dc_y_p1;
   logic                    vld_p1;

   // y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), clamped to the accumulator width
   function automatic logic signed [DC_W-1:0] dc_step(
      input logic signed [OUT_W-1:0] x,
      input logic signed [OUT_W-1:0] xp,
      input logic signed [DC_W-1:0]  y
   );
      logic signed [DC_W-1:0]  ys;
      logic signed [DC_W+1:0]  xe, xpe, ye, yse, acc;
      ys  = y >>> 8;
      xe  = {{(DC_W+2-OUT_W){x[OUT_W-1]}}, x};
      xpe = {{(DC_W+2-OUT_W){xp[OUT_W-1]}}, xp};
      ye  = {{2{y[DC_W-1]}}, y};
      yse = {{2{ys[DC_W-1]}}, ys};
      acc = xe - xpe + ye - yse;
      if (acc > DC_MAX) return DC_MAX[DC_W-1:0];
      else if (acc < DC_MIN) return DC_MIN[DC_W-1:0];
      return acc[DC_W-1:0];
   endfunction

   // DC-blocking stage, updated only for samples that survive the settle discard
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         dc_x_p1 <= '0;
         dc_y_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            dc_x_p1 <= pcm_p0;
            dc_y_p1 <= dc_step(pcm_p0, dc_x_p1, dc_y_p1);
         end
      end
   end

   assign out_vld = vld_p1;
   assign out_val = sat_out({{(SW-DC_W){dc_y_p1[DC_W-1]}}, dc_y_p1});
`else
   assign out_vld = vld_p0;
   assign out_val = pcm_p0;
`endif

   // output holding register: a new sample always wins, dropping an unread one sets overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (out_vld) begin
         sample       <= out_val;
         sample_valid <= 1'b1;
         if (sample_valid && !sample_ready) overrun <= 1'b1;
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator (default build): divider timing, reset
// values, DC responses, square-wave response against a direct-convolution CIC
// reference, valid/ready handshake with overrun, and mid-run reset.
`timescale 1ns/1ps
module tb_pdm_cic_decimator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pdm_data = 1'b0;
   logic sample_ready = 1'b0;
   logic pdm_clk;
   logic signed [15:0] sample;
   logic sample_valid;
   logic overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int mode = 1;
   int bit_idx = 0;
   int h [0:252];

   pdm_cic_decimator #(.CLK_DIV(10), .DECIM_LOG2(6), .OUT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .pdm_clk      (pdm_clk),
      .pdm_data     (pdm_data),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // bit k (1-based) of each stimulus pattern
   function automatic bit pat(input int md, input int k);
      case (md)
         1: return 1'b1;
         2: return bit'(k % 2);
         3: return (((k - 1) / 512) % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   // reference: direct convolution with the 4-fold 64-tap boxcar, >>>9, saturate
   function automatic int exp_out(input int md, input int m);
      longint acc;
      int k;
      acc = 0;
      for (int j = 0; j < 253; j++) begin
         k = m * 64 - j;
         if (k >= 1) acc += pat(md, k) ? longint'(h[j]) : -longint'(h[j]);
      end
      acc = acc >>> 9;
      if (acc > 32767) return 32767;
      if (acc < -32768) return -32768;
      return int'(acc);
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (sample_valid !== 1'b1 && t < 20000);
      check({tag, "_seen"}, sample_valid, 1);
   endtask

   task automatic do_reset(input int md);
      @(negedge clk);
      rst  = 1'b1;
      mode = md;
      @(negedge clk);
      rst  = 1'b0;
   endtask

   // microphone model: a new bit after each rising pdm_clk, index restarts on reset
   initial forever begin
      @(posedge pdm_clk or posedge rst);
      if (rst) begin
         bit_idx = 0;
      end else begin
         bit_idx  = bit_idx + 1;
         pdm_data = pat(mode, bit_idx);
      end
   end

   initial begin
      int a [0:252];
      int b [0:252];
      int e17, e18, e19;
      for (int i = 0; i < 253; i++) a[i] = (i < 64) ? 1 : 0;
      repeat (3) begin
         for (int i = 0; i < 253; i++) begin
            b[i] = 0;
            for (int j = 0; j < 64; j++) if (i - j >= 0) b[i] += a[i - j];
         end
         a = b;
      end
      h = a;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_pdm_clk", pdm_clk, 0);
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_overrun", overrun, 0);

      // divider: low for 10 clk, then 10 high, 10 low
      rst = 1'b0;
      repeat (9) @(negedge clk);
      check("div_low", pdm_clk, 0);
      @(negedge clk);
      check("div_rise", pdm_clk, 1);
      repeat (9) @(negedge clk);
      check("div_high", pdm_clk, 1);
      @(negedge clk);
      check("div_fall", pdm_clk, 0);

      // all ones
      sample_ready = 1'b1;
      wait_valid("ones5");
      check("ones_latency_ticks", bit_idx, 320);
      check("ones_s5", sample, 32767);
      wait_valid("ones6");
      check("ones_s6", sample, 32767);
      check("ones_overrun", overrun, 0);

      // all zeros
      do_reset(0);
      wait_valid("zeros5");
      check("zeros_s5", sample, -32768);
      wait_valid("zeros6");
      check("zeros_s6", sample, -32768);

      // alternating
      do_reset(2);
      wait_valid("alt5");
      check("alt_s5", sample, 0);
      wait_valid("alt6");
      check("alt_s6", sample, 0);

      // square wave, toggling every 512 bits
      do_reset(3);
      for (int m = 5; m <= 16; m++) begin
         wait_valid($sformatf("sq%0d", m));
         check($sformatf("sq_s%0d", m), sample, exp_out(3, m));
      end

      // handshake: hold, coincident accept, then overrun
      e17 = exp_out(3, 17);
      e18 = exp_out(3, 18);
      e19 = exp_out(3, 19);
      @(negedge clk);
      sample_ready = 1'b0;
      wait_valid("hs17");
      check("hs_s17", sample, e17);
      check("hs_overrun0", overrun, 0);
      repeat (1279) @(negedge clk);
      check("hs_stable_sample", sample, e17);
      check("hs_stable_valid", sample_valid, 1);
      check("hs_stable_overrun", overrun, 0);
      sample_ready = 1'b1;
      @(negedge clk);
      check("hs_coinc_sample", sample, e18);
      check("hs_coinc_valid", sample_valid, 1);
      check("hs_coinc_overrun", overrun, 0);
      sample_ready = 1'b0;
      repeat (1280) @(negedge clk);
      check("ovr_sample", sample, e19);
      check("ovr_valid", sample_valid, 1);
      check("ovr_flag", overrun, 1);

      // mid-run reset clears everything and repeats the settle discard
      do_reset(1);
      check("mrst_pdm_clk", pdm_clk, 0);
      check("mrst_sample", sample, 0);
      check("mrst_valid", sample_valid, 0);
      check("mrst_overrun", overrun, 0);
      sample_ready = 1'b1;
      wait_valid("mrst5");
      check("mrst_latency_ticks", bit_idx, 320);
      check("mrst_s5", sample, 32767);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
